// File: rtl/rf_write_port_arbiter.sv
// Arbitrates the single register-file write port between in-order writeback and
// a small FIFO of long-latency results, with a starvation guard for the FIFO.
module rf_write_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int IDX_W        = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IDX_W-1:0]         wb_index,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_en,
  output logic                     wb_stall,
  input  logic                     lu_valid,
  input  logic [IDX_W-1:0]         lu_index,
  input  logic [DATA_W-1:0]        lu_data,
  output logic                     lu_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [IDX_W-1:0]         write_index_rf,
  output logic [DATA_W-1:0]        write_data_rf,
  output logic                     write_en_rf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int ENT_W = IDX_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  // Handshake: an lu result is taken on a cycle where lu_valid && lu_ready;
  // writeback is taken when wb_en && !wb_stall, otherwise it holds its inputs.

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              en_q, en_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic             fifo_ne;
  logic             grant_fifo;
  logic             grant_wb;
  logic             enq;
  logic [ENT_W-1:0] head;

  always_comb begin
    fifo_ne    = (count_q != '0);
    lu_ready   = (count_q < DEPTH_C);
    grant_fifo = fifo_ne && (!wb_en || (starve_q == LIMIT_C));
    grant_wb   = wb_en && !grant_fifo;
    wb_stall   = wb_en && grant_fifo;
    enq        = lu_valid && lu_ready;
    head       = mem_q[rd_ptr_q];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) begin
      mem_d[wr_ptr_q] = {lu_index, lu_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (grant_fifo) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({enq, grant_fifo})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Counts writeback wins only while something is waiting in the FIFO.
    if (grant_fifo || !fifo_ne) begin
      starve_d = '0;
    end else if (grant_wb && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + STV_W'(1);
    end else begin
      starve_d = starve_q;
    end

    en_d   = grant_fifo || grant_wb;
    idx_d  = idx_q;
    data_d = data_q;
    if (grant_fifo) begin
      {idx_d, data_d} = head;
    end else if (grant_wb) begin
      idx_d  = wb_index;
      data_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      en_q     <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      en_q     <= en_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end

  assign fifo_count     = count_q;
  assign write_en_rf    = en_q;
  assign write_index_rf = idx_q;
  assign write_data_rf  = data_q;

endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// Bench for rf_write_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of the arbitration rules.
module tb_rf_write_port_arbiter;
  localparam int DATA_W       = 16;
  localparam int IDX_W        = 5;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int ENT_W        = IDX_W + DATA_W;

  logic              clk;
  logic              rst;
  logic [IDX_W-1:0]  wb_index;
  logic [DATA_W-1:0] wb_data;
  logic              wb_en;
  logic              wb_stall;
  logic              lu_valid;
  logic [IDX_W-1:0]  lu_index;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic [1:0]        fifo_count;
  logic [IDX_W-1:0]  write_index_rf;
  logic [DATA_W-1:0] write_data_rf;
  logic              write_en_rf;

  int total;
  int bad;

  // Model state: pending lu entries and what the RF port should show.
  logic [ENT_W-1:0]  exp_q[$];
  int                m_starve;
  logic              m_en;
  logic [IDX_W-1:0]  m_idx;
  logic [DATA_W-1:0] m_data;
  logic              obs_stall, obs_ready;
  logic              exp_stall, exp_ready, lu_taken;

  rf_write_port_arbiter #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_index(wb_index), .wb_data(wb_data), .wb_en(wb_en), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_index(lu_index), .lu_data(lu_data), .lu_ready(lu_ready),
    .fifo_count(fifo_count), .write_index_rf(write_index_rf),
    .write_data_rf(write_data_rf), .write_en_rf(write_en_rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    exp_q.delete();
    m_starve = 0;
    m_en     = 1'b0;
    m_idx    = '0;
    m_data   = '0;
  endtask

  // One clock: drive inputs, sample combinational outputs at negedge, advance model.
  task automatic tick(input logic wbe, input logic [IDX_W-1:0] wi, input logic [DATA_W-1:0] wd,
                      input logic luv, input logic [IDX_W-1:0] li, input logic [DATA_W-1:0] ld);
    int               sz;
    logic             take;
    logic [ENT_W-1:0] e;
    wb_en = wbe; wb_index = wi; wb_data = wd;
    lu_valid = luv; lu_index = li; lu_data = ld;
    @(negedge clk);
    obs_stall = wb_stall;
    obs_ready = lu_ready;
    sz        = exp_q.size();
    exp_ready = (sz < DEPTH);
    take      = (sz != 0) && (!wbe || m_starve == STARVE_LIMIT);
    exp_stall = wbe && take;
    lu_taken  = luv && exp_ready;
    if (take) begin
      e = exp_q.pop_front();
      m_en = 1'b1;
      m_idx  = e[ENT_W-1:DATA_W];
      m_data = e[DATA_W-1:0];
      m_starve = 0;
    end else begin
      m_en = wbe;
      if (wbe) begin
        m_idx  = wi;
        m_data = wd;
      end
      if (sz == 0) m_starve = 0;
      else if (wbe && m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
    end
    if (lu_taken) exp_q.push_back({li, ld});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_en = 1'b0; wb_index = '0; wb_data = '0;
    lu_valid = 1'b0; lu_index = '0; lu_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (write_en_rf !== 1'b0) begin bad++; $display("FAIL reset_en: got %0b want 0", write_en_rf); end
    total++; if (write_index_rf !== 5'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", write_index_rf); end
    total++; if (write_data_rf !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0000", write_data_rf); end
    total++; if (fifo_count !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", lu_ready); end
    total++; if (wb_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", wb_stall); end
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_wb_basic();
    tick(1'b1, 5'd3, 16'h1234, 1'b0, '0, '0);
    total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL wb_stall: got %0b want 0", obs_stall); end
    total++; if (write_en_rf !== 1'b1) begin bad++; $display("FAIL wb_en_rf: got %0b want 1", write_en_rf); end
    total++; if (write_index_rf !== 5'd3) begin bad++; $display("FAIL wb_idx: got %0d want 3", write_index_rf); end
    total++; if (write_data_rf !== 16'h1234) begin bad++; $display("FAIL wb_data: got %h want 1234", write_data_rf); end
    tick(1'b0, '0, '0, 1'b0, '0, '0);
    total++; if (write_en_rf !== 1'b0) begin bad++; $display("FAIL wb_idle_en: got %0b want 0", write_en_rf); end
    total++; if (write_data_rf !== 16'h1234) begin bad++; $display("FAIL wb_hold_data: got %h want 1234", write_data_rf); end
  endtask

  task automatic test_lu_basic();
    tick(1'b0, '0, '0, 1'b1, 5'd7, 16'hBEEF);
    total++; if (fifo_count !== 2'd1) begin bad++; $display("FAIL lu_count1: got %0d want 1", fifo_count); end
    total++; if (write_en_rf !== 1'b0) begin bad++; $display("FAIL lu_early_en: got %0b want 0", write_en_rf); end
    tick(1'b0, '0, '0, 1'b0, '0, '0);
    total++; if (write_en_rf !== 1'b1) begin bad++; $display("FAIL lu_en: got %0b want 1", write_en_rf); end
    total++; if (write_index_rf !== 5'd7) begin bad++; $display("FAIL lu_idx: got %0d want 7", write_index_rf); end
    total++; if (write_data_rf !== 16'hBEEF) begin bad++; $display("FAIL lu_data: got %h want beef", write_data_rf); end
    total++; if (fifo_count !== 2'd0) begin bad++; $display("FAIL lu_count0: got %0d want 0", fifo_count); end
  endtask

  task automatic test_starve();
    int n;
    int first_stall;
    logic [DATA_W-1:0] want;
    tick(1'b0, '0, '0, 1'b1, 5'd9, 16'hA5A5);
    for (int i = 0; i < 10; i++) begin
      n = (i > 4) ? i - 1 : i;
      tick(1'b1, 5'd4, 16'h0100 + 16'(n), 1'b0, '0, '0);
      want = (i == 4) ? 16'hA5A5 : 16'h0100 + 16'(n);
      total++; if (obs_stall !== (i == 4)) begin bad++; $display("FAIL starve_stall[%0d]: got %0b want %0b", i, obs_stall, (i == 4)); end
      total++; if (write_en_rf !== 1'b1 || write_data_rf !== want) begin bad++; $display("FAIL starve_write[%0d]: got en=%0b data=%h want en=1 data=%h", i, write_en_rf, write_data_rf, want); end
    end
    // A fresh entry must again wait exactly STARVE_LIMIT writeback wins.
    tick(1'b1, 5'd4, 16'h0110, 1'b1, 5'd10, 16'h5A5A);
    first_stall = -1;
    n = 0;
    for (int j = 0; j < 6; j++) begin
      tick(1'b1, 5'd4, 16'h0111 + 16'(n), 1'b0, '0, '0);
      if (obs_stall && first_stall < 0) first_stall = j;
      if (!obs_stall) n++;
    end
    total++; if (first_stall !== STARVE_LIMIT) begin bad++; $display("FAIL starve_rearm: got stall at %0d want %0d", first_stall, STARVE_LIMIT); end
  endtask

  task automatic test_fill();
    int k, n, lu_writes;
    logic luv_hold, saw_full;
    logic [DATA_W-1:0] lu_next;
    k = 0; n = 0; lu_writes = 0; saw_full = 1'b0; lu_next = 16'hC000;
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, 5'd2, 16'h0200 + 16'(n), 1'b1, 5'd12, 16'hC000 + 16'(k));
      luv_hold = !lu_taken;
      if (!obs_ready) saw_full = 1'b1;
      if (lu_taken) k++;
      if (!exp_stall) n++;
      total++; if (obs_ready !== exp_ready || fifo_count !== 2'(exp_q.size())) begin bad++; $display("FAIL fill_occ[%0d]: got ready=%0b count=%0d want ready=%0b count=%0d", i, obs_ready, fifo_count, exp_ready, exp_q.size()); end
      if (write_data_rf[15:12] == 4'hC) begin
        lu_writes++;
        total++; if (write_data_rf !== lu_next) begin bad++; $display("FAIL fill_order[%0d]: got %h want %h", i, write_data_rf, lu_next); end
        lu_next = lu_next + 16'h1;
      end
      if (luv_hold) begin end
    end
    total++; if (!saw_full || lu_writes < 3) begin bad++; $display("FAIL fill_cover: got full=%0b lu_writes=%0d want full=1 lu_writes>=3", saw_full, lu_writes); end
    repeat (4) tick(1'b0, '0, '0, 1'b0, '0, '0);
    total++; if (fifo_count !== 2'd0) begin bad++; $display("FAIL fill_drain: got %0d want 0", fifo_count); end
  endtask

  task automatic test_wrap();
    tick(1'b0, '0, '0, 1'b1, 5'd1, 16'hD000);
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, '0, '0, 1'b1, 5'(k + 2), 16'hD001 + 16'(k));
      total++; if (fifo_count !== 2'd1) begin bad++; $display("FAIL wrap_count[%0d]: got %0d want 1", k, fifo_count); end
      total++; if (write_en_rf !== 1'b1 || write_index_rf !== 5'(k + 1) || write_data_rf !== 16'hD000 + 16'(k)) begin bad++; $display("FAIL wrap_data[%0d]: got en=%0b idx=%0d data=%h want en=1 idx=%0d data=%h", k, write_en_rf, write_index_rf, write_data_rf, k + 1, 16'hD000 + 16'(k)); end
    end
    tick(1'b0, '0, '0, 1'b0, '0, '0);
    total++; if (write_data_rf !== 16'hD006 || fifo_count !== 2'd0) begin bad++; $display("FAIL wrap_last: got data=%h count=%0d want data=d006 count=0", write_data_rf, fifo_count); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 5'd5, 16'h0300, 1'b1, 5'd13, 16'hE000);
    tick(1'b1, 5'd5, 16'h0301, 1'b1, 5'd14, 16'hE001);
    total++; if (fifo_count !== 2'd2 || write_en_rf !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got count=%0d en=%0b want count=2 en=1", fifo_count, write_en_rf); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (write_en_rf !== 1'b0 || write_index_rf !== 5'd0 || write_data_rf !== 16'h0) begin bad++; $display("FAIL rstmid_out: got en=%0b idx=%0d data=%h want 0", write_en_rf, write_index_rf, write_data_rf); end
    total++; if (fifo_count !== 2'd0 || lu_ready !== 1'b1) begin bad++; $display("FAIL rstmid_fifo: got count=%0d ready=%0b want count=0 ready=1", fifo_count, lu_ready); end
    wb_en = 1'b0; lu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, '0, 1'b0, '0, '0);
      total++; if (write_en_rf !== 1'b0 || fifo_count !== 2'd0) begin bad++; $display("FAIL rstmid_stale[%0d]: got en=%0b count=%0d want en=0 count=0", i, write_en_rf, fifo_count); end
    end
  endtask

  task automatic test_random();
    logic wbe, luv;
    logic [IDX_W-1:0] wi, li;
    logic [DATA_W-1:0] wd, ld;
    wbe = 1'b0; luv = 1'b0; wi = '0; li = '0; wd = '0; ld = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(wbe && exp_stall)) begin
        wbe = ($urandom_range(0, 99) < 65);
        wi  = 5'($urandom_range(0, 31));
        wd  = 16'($urandom);
      end
      if (!(luv && !lu_taken)) begin
        luv = ($urandom_range(0, 99) < 35);
        li  = 5'($urandom_range(0, 31));
        ld  = 16'($urandom);
      end
      tick(wbe, wi, wd, luv, li, ld);
      total++; if (obs_stall !== exp_stall || obs_ready !== exp_ready) begin bad++; $display("FAIL rand_hs[%0d]: got stall=%0b ready=%0b want stall=%0b ready=%0b", i, obs_stall, obs_ready, exp_stall, exp_ready); end
      total++; if (fifo_count !== 2'(exp_q.size())) begin bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, fifo_count, exp_q.size()); end
      total++; if (write_en_rf !== m_en || write_index_rf !== m_idx || write_data_rf !== m_data) begin bad++; $display("FAIL rand_write[%0d]: got en=%0b idx=%0d data=%h want en=%0b idx=%0d data=%h", i, write_en_rf, write_index_rf, write_data_rf, m_en, m_idx, m_data); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_stall = 1'b0; exp_ready = 1'b1; lu_taken = 1'b0;
    obs_stall = 1'b0; obs_ready = 1'b1;
    model_reset();
    test_reset();
    test_wb_basic();
    test_lu_basic();
    test_starve();
    test_fill();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
